// File: rtl/hc_pkg.sv
// Shared types, constants and the round-robin pick helper for the adder arbiter.
package hc_pkg;

   localparam int HC_WIDTH   = 16;
   localparam int HC_ADD_LAT = 7;
   localparam int HC_NUM_REQ = 4;
   localparam int HC_IDW     = $clog2(HC_NUM_REQ);

   // One response FIFO entry: who asked, and what the adder produced.
   typedef struct packed {
      logic [HC_IDW-1:0]   id;
      logic [HC_WIDTH-1:0] sum;
      logic                cout;
   } hc_rsp_t;

   // Returns {found, idx}: the first set bit of valid at or after ptr,
   // searching cyclically.
   function automatic logic [HC_IDW:0] rr_pick(input logic [HC_NUM_REQ-1:0] valid,
                                               input logic [HC_IDW-1:0]     ptr);
      logic              found;
      logic [HC_IDW-1:0] idx;
      int                c;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < HC_NUM_REQ; k++) begin
         c = (int'(ptr) + k) % HC_NUM_REQ;
         if (!found && valid[c]) begin
            found = 1'b1;
            idx   = c[HC_IDW-1:0];
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/hc_add_arbiter_if.sv
// Requester, adder and response buses of the shared-adder arbiter.
interface hc_add_arbiter_if #(
   parameter int NUM_REQ = hc_pkg::HC_NUM_REQ,
   parameter int WIDTH   = hc_pkg::HC_WIDTH
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]            req_cin;

   logic [WIDTH-1:0]              add_a;
   logic [WIDTH-1:0]              add_b;
   logic                          add_cin;
   logic [WIDTH-1:0]              add_sum;
   logic                          add_cout;

   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [IDW-1:0]                rsp_id;
   logic [WIDTH-1:0]              rsp_sum;
   logic                          rsp_cout;

   // Requesters, adder and response consumer.
   modport master (
      output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
      input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );

   // The arbiter itself.
   modport slave (
      input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
      output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );
endinterface

// File: rtl/hc_rsp_fifo.sv
// Response FIFO: flop-based ring, head presented from registers, push and pop
// may coincide at any occupancy.
module hc_rsp_fifo
   import hc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  hc_rsp_t                    din,
   input  logic                       pop,
   output logic                       dout_valid,
   output hc_rsp_t                    dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   hc_rsp_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Pointer and occupancy update; a pop on an empty FIFO is ignored.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = push   ? bump(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? bump(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(do_pop);
   end

   // Control state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; when full, the slot written is the one being popped.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= din;
   end

   assign dout_valid = (count_q != '0);
   assign dout       = dout_valid ? mem[rd_ptr_q] : '0;
   assign count      = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count_q == CW'(DEPTH)) && !do_pop));

endmodule

// File: rtl/hc_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined adder; results are
// tagged with the requester ID and queued in a credit-protected FIFO.
module hc_add_arbiter
   import hc_pkg::*;
#(
   parameter int NUM_REQ   = HC_NUM_REQ,
   parameter int WIDTH     = HC_WIDTH,
   parameter int ADD_LAT   = HC_ADD_LAT,
   parameter int RSP_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   hc_add_arbiter_if.slave bus,
   output logic            idle
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int LW  = $clog2(ADD_LAT + 1);
   localparam int CW  = $clog2(RSP_DEPTH + 1);

   logic [IDW:0]                  pick;
   logic [IDW-1:0]                grant_idx;
   logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]            grant;
   logic                          issue, can_issue, pop, wr;
   int                            used;
   logic [WIDTH-1:0]              mux_a, mux_b;
   logic                          mux_cin;
   logic [ADD_LAT-1:0]            vld_q, vld_d;
   logic [ADD_LAT-1:0][IDW-1:0]   id_q, id_d;
   logic [LW-1:0]                 inflight_q, inflight_d;
   logic [CW-1:0]                 fifo_count;
   logic                          head_valid;
   hc_rsp_t                       wr_data, head;

   // Credits and arbitration; a pop this cycle frees its slot for an issue
   // this cycle, which keeps back-to-back throughput with the consumer ready.
   always_comb begin
      pop       = head_valid & bus.rsp_ready;
      used      = int'(fifo_count) + int'(inflight_q) - int'(pop);
      can_issue = (used < RSP_DEPTH);
      pick      = rr_pick(bus.req_valid, rr_ptr_q);
      grant_idx = pick[IDW-1:0];
      issue     = can_issue & pick[IDW];
      grant     = '0;
      if (issue) grant[grant_idx] = 1'b1;
      rr_ptr_d  = rr_ptr_q;
      if (issue) rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
   end

   // Granted requester's operands to the adder, zeros when nothing issues.
   always_comb begin
      mux_a   = '0;
      mux_b   = '0;
      mux_cin = 1'b0;
      if (issue) begin
         mux_a   = bus.req_a[grant_idx];
         mux_b   = bus.req_b[grant_idx];
         mux_cin = bus.req_cin[grant_idx];
      end
   end

   // Tag pipe mirrors the adder latency; the last stage marks a valid result.
   always_comb begin
      vld_d      = {vld_q[ADD_LAT-2:0], issue};
      id_d       = {id_q[ADD_LAT-2:0], grant_idx};
      wr         = vld_q[ADD_LAT-1];
      wr_data    = '{id: id_q[ADD_LAT-1], sum: bus.add_sum, cout: bus.add_cout};
      inflight_d = inflight_q + LW'(issue) - LW'(wr);
   end

   // Arbiter pointer, tag pipe and in-flight count; reset drops in-flight ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         vld_q      <= '0;
         id_q       <= '0;
         inflight_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         vld_q      <= vld_d;
         id_q       <= id_d;
         inflight_q <= inflight_d;
      end
   end

   hc_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (wr),
      .din        (wr_data),
      .pop        (pop),
      .dout_valid (head_valid),
      .dout       (head),
      .count      (fifo_count)
   );

   assign bus.req_ready = grant;
   assign bus.add_a     = mux_a;
   assign bus.add_b     = mux_b;
   assign bus.add_cin   = mux_cin;
   assign bus.rsp_valid = head_valid;
   assign bus.rsp_id    = head.id;
   assign bus.rsp_sum   = head.sum;
   assign bus.rsp_cout  = head.cout;
   assign idle          = (inflight_q == '0) && (fifo_count == '0);

endmodule
